keypad_event_reader: RTL

KEYPAD_EVENT_READER -- requirements
Module: keypad_event_reader

---
 rtl/keypad_pkg.sv | 7 +
 rtl/key_fifo.sv | 49 ++++
 rtl/keypad_event_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad event reader: key code, debounce states and
// the reserved "no key" code.
package keypad_pkg;
  typedef logic [3:0] key_t;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} db_state_t;
  localparam key_t KEY_NONE = 4'd13;
endpackage

// File: rtl/key_fifo.sv
// Key-event FIFO with wrapping pointers. A pop in the same cycle as a push on
// a full queue frees the slot, so the push is kept instead of dropped.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        gclk,
  input  logic                        grst_n,
  input  logic                        push,
  input  logic                        pop,
  input  key_t                        din,
  output key_t                        head,
  output logic                        full,
  output logic                        empty,
  output logic                        drop,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  key_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/keypad_event_reader.sv
// Debounces a scanned keypad (press and release each need DB_CYCLES stable
// samples) and queues one event per accepted press for an MCU to pop.
module keypad_event_reader
  import keypad_pkg::*;
#(
  parameter int DB_CYCLES  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [3:0]                  DATA,
  input  logic                        PRESS,
  input  logic                        RD,
  input  logic                        CLR_OVF,
  output logic [3:0]                  KEY_OUT,
  output logic                        VALID,
  output logic                        INT,
  output logic                        OVF,
  output logic [$clog2(FIFO_DEPTH):0] COUNT
);
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  key_t       data_q, cand;
  logic       press_q;
  db_state_t  state;
  logic [7:0] cnt;
  logic       push, empty, full, drop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q  <= '0;
      press_q <= 1'b0;
    end else begin
      data_q  <= DATA;
      press_q <= PRESS;
    end
  end

  // The push fires on the sample that brings the stable run up to DB_CYCLES.
  assign push = (state == PRESS_WAIT) && press_q && (data_q == cand) && (cnt == DB_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      INT   <= 1'b0;
    end else begin
      INT <= push;
      case (state)
        IDLE: if (press_q) begin
          state <= PRESS_WAIT;
          cand  <= data_q;
          cnt   <= 8'd1;
        end
        PRESS_WAIT: begin
          if (!press_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (data_q != cand) begin
            cand <= data_q;
            cnt  <= 8'd1;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: if (!press_q) begin
          state <= REL_WAIT;
          cnt   <= 8'd1;
        end
        REL_WAIT: begin
          if (press_q) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A drop in the clearing cycle wins so no lost event goes unreported.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       OVF <= 1'b0;
    else if (drop)    OVF <= 1'b1;
    else if (CLR_OVF) OVF <= 1'b0;
  end

  key_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk   (CLK),
    .grst_n (RST_N),
    .push   (push),
    .pop    (RD),
    .din    (cand),
    .head   (KEY_OUT),
    .full   (full),
    .empty  (empty),
    .drop   (drop),
    .count  (COUNT)
  );

  assign VALID = !empty;
endmodule
